ram_scan_reader: RTL and testbench
==================================

RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 Parameter TICK_DIV, default 50000000, SHALL set the clk cycles per auto-advance (1 Hz at 50 MHz); legal range is 2 or greater.
REQ-002 Parameter ADDR_W, default 5, SHALL set the read address width (32 words).
REQ-003 Parameter DATA_W, default 4, SHALL set the read data width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port run, input, 1 bit, SHALL select the mode: 1 = auto-scan on tick, 0 = manual step.
REQ-007 Port step, input, 1 bit, SHALL be a single-cycle, synchronized advance request, honoured only when run=0.
REQ-008 Port rd_addr, output, ADDR_W bits, SHALL drive the read address of a synchronous RAM read port.
REQ-009 Port rd_data, input, DATA_W bits, SHALL carry RAM read data, valid one clk edge after rd_addr is sampled.
REQ-010 Port disp_addr, output, ADDR_W bits, SHALL hold the address of the last completed read.
REQ-011 Port disp_data, output, DATA_W bits, SHALL hold the data of the last completed read.
REQ-012 Port disp_valid, output, 1 bit, SHALL indicate that disp_addr and disp_data hold a completed read.
REQ-013 Port wrap, output, 1 bit, SHALL pulse for one cycle when rd_addr wraps from 2^ADDR_W-1 to 0.
REQ-014 Port busy, output, 1 bit, SHALL be high while a read is in flight (states WAIT and LATCH).

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and LATCH.
REQ-016 IDLE SHALL transition to WAIT on an advance event, defined as a tick when run=1 or step=1 when run=0.
- On that same edge, rd_addr increments modulo 2^ADDR_W.
REQ-017 WAIT SHALL transition to LATCH unconditionally on the next edge.
REQ-018 In LATCH, on the next edge, the block SHALL:
- set disp_data to rd_data;
- set disp_addr to rd_addr;
- set disp_valid to 1;
- return to IDLE.
REQ-019 An advance accepted at edge N SHALL update the disp outputs at edge N+2.
REQ-020 Advance events arriving in WAIT or LATCH SHALL be dropped, not queued.
REQ-021 The tick counter SHALL:
- count 0 to TICK_DIV-1 while run=1;
- generate a tick on the cycle it equals TICK_DIV-1, then wrap to 0;
- be held at 0 while run=0.
REQ-022 The tick counter SHALL keep counting regardless of FSM state.
- A tick landing in WAIT or LATCH is lost per REQ-020.
REQ-023 step SHALL be ignored while run=1.
- run and step asserted together SHALL produce no advance unless a tick occurs that cycle.
REQ-024 wrap SHALL assert in the cycle after the edge on which rd_addr goes from 31 to 0, and be 0 otherwise.
REQ-025 rd_addr SHALL change only on an accepted advance; disp outputs SHALL change only in LATCH.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force the following values, regardless of any read in flight:
- rd_addr=0, disp_addr=0, disp_data=0;
- disp_valid=0, wrap=0;
- tick counter=0.
REQ-027 During reset the FSM SHALL be forced to WAIT, so the first edges after release perform a priming read of address 0.
- disp_valid=1 and disp_addr=0 at the 2nd edge after release.
REQ-028 reset_n asserted mid-read SHALL discard the read with no disp update.

Verification (bench uses TICK_DIV=4; RAM model preloaded with mem[a]=a[3:0]^4'hA)
REQ-029 Reset release, run=0 -> after 2 edges: disp_valid=1, disp_addr=0, disp_data=A; holds with no step.
REQ-030 run=0, three step pulses spaced 4 cycles apart -> disp_addr 1, 2, 3 and disp_data B, 8, 9, each 2 edges after its pulse.
REQ-031 run=1 for 40 cycles -> one advance every 4 cycles, disp_addr increments by 1 each; step pulses during this window have no effect.
REQ-032 Step to addr 31, then one more step -> rd_addr=0, wrap high exactly 1 cycle, disp_addr=0, disp_data=A.
REQ-033 Step pulse, then a second step one cycle later while busy=1 -> only one advance occurs.
REQ-034 reset_n pulled low in WAIT after advancing from 5 to 6 -> all outputs 0 immediately; after release, address 0 is re-primed.

Source files
------------

// File: rtl/ram_scan_reader.sv
// Scans a synchronous-read RAM one word at a time, either on a divided tick
// (run=1) or on manual step pulses (run=0), and holds the last completed read.
module ram_scan_reader #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             advance;

  assign tick    = run && (tick_cnt == TICK_LAST);
  assign advance = (state == IDLE) && (run ? tick : step);
  assign busy    = (state != IDLE);

  // Free-running divider: counts whenever run=1, independent of the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!run || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Reset parks the FSM in WAIT with rd_addr=0 so address 0 is read on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT;
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (advance) begin
            rd_addr <= rd_addr + 1'b1;
            wrap    <= (rd_addr == '1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          state <= LATCH;
        end
        LATCH: begin
          disp_addr  <= rd_addr;
          disp_data  <= rd_data;
          disp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomized self-checking bench for ram_scan_reader against a cycle-level
// reference model built from the scan/latch rules (TICK_DIV=4, 32x4 RAM).
module tb_ram_scan_reader;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       step;
  logic [4:0] rd_addr;
  logic [3:0] rd_data;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid;
  logic       wrap;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_scan_reader #(.TICK_DIV(TICK_DIV), .ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wrap(wrap), .busy(busy)
  );

  // Synchronous-read RAM preloaded with mem[a] = a[3:0] ^ 4'hA
  logic [3:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = i[3:0] ^ 4'hA;
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Reference model: an advance is taken only when no read is outstanding;
  // a read stays outstanding for two edges, then the display shows the word.
  logic [4:0] m_rd, m_daddr;
  logic [3:0] m_ddata;
  logic       m_valid, m_wrap;
  int         m_cnt, m_left;

  always @(posedge clk or negedge reset_n) begin : ref_model
    int left, cnt;
    logic [4:0] a;
    logic wr;
    if (!reset_n) begin
      m_rd <= '0; m_daddr <= '0; m_ddata <= '0; m_valid <= 1'b0;
      m_wrap <= 1'b0; m_cnt <= 0; m_left <= 2;
    end else begin
      a = m_rd; left = m_left; wr = 1'b0;
      cnt = run ? ((m_cnt + 1) % TICK_DIV) : 0;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          m_daddr <= a; m_ddata <= a[3:0] ^ 4'hA; m_valid <= 1'b1;
        end
      end else if (run ? (m_cnt == TICK_DIV - 1) : step) begin
        a = a + 5'd1; wr = (a == 5'd0); left = 2;
      end
      m_rd <= a; m_left <= left; m_cnt <= cnt; m_wrap <= wr;
    end
  end

  logic [16:0] obs, exp_v;
  assign obs   = {rd_addr, disp_addr, disp_data, disp_valid, wrap, busy};
  assign exp_v = {m_rd, m_daddr, m_ddata, m_valid, m_wrap, (m_left != 0)};

  task automatic test_reset();
    run = 1'b0; step = 1'b0; reset_n = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, disp_addr, disp_data, disp_valid, wrap} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", {rd_addr, disp_addr, disp_data, disp_valid, wrap});
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({disp_valid, disp_addr, disp_data} !== {1'b1, 5'd0, 4'hA}) begin
      miscompares++;
      $display("FAIL reset_prime got v=%b a=%0d d=%h want v=1 a=0 d=a", disp_valid, disp_addr, disp_data);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v || disp_addr !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_step();
    logic [3:0] want_d [3] = '{4'hB, 4'h8, 4'h9};
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (disp_addr !== 5'(k + 1) || disp_data !== want_d[k] || obs !== exp_v) begin
        miscompares++;
        $display("FAIL step_%0d got a=%0d d=%h (%h) want a=%0d d=%h (%h)",
                 k, disp_addr, disp_data, obs, k + 1, want_d[k], exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_auto_scan();
    logic [4:0] start;
    start = m_rd;
    run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL auto_scan cyc %0d got %h want %h", c, obs, exp_v);
      end
    end
    vectors++;
    if (rd_addr !== start + 5'd10) begin
      miscompares++;
      $display("FAIL auto_count got %0d want %0d", rd_addr, start + 5'd10);
    end
    run = 1'b0; step = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL auto_drain cyc %0d got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (m_rd != 5'd31 && guard < 40) begin
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL wrap_walk step %0d got %h want %h", guard, obs, exp_v);
        end
      end
      guard++;
    end
    vectors++;
    if (rd_addr !== 5'd31) begin
      miscompares++;
      $display("FAIL wrap_reach got %0d want 31", rd_addr);
    end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    vectors++;
    if (rd_addr !== 5'd0 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pulse got addr=%0d wrap=%b want addr=0 wrap=1", rd_addr, wrap);
    end
    @(negedge clk);
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_width got %b want 0", wrap);
    end
    @(negedge clk);
    vectors++;
    if ({disp_valid, disp_addr, disp_data} !== {1'b1, 5'd0, 4'hA} || obs !== exp_v) begin
      miscompares++;
      $display("FAIL wrap_disp got a=%0d d=%h want a=0 d=a", disp_addr, disp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] start;
    start = m_rd;
    step = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_busy got %b want 1", busy);
    end
    @(negedge clk); step = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_addr !== start + 5'd1 || disp_addr !== start + 5'd1 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_single got rd=%0d disp=%0d want %0d", rd_addr, disp_addr, start + 5'd1);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (m_rd != 5'd5 && guard < 40) begin
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (3) @(negedge clk);
      guard++;
    end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    vectors++;
    if (rd_addr !== 5'd6 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_adv got rd=%0d busy=%b want rd=6 busy=1", rd_addr, busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, disp_addr, disp_data, disp_valid, wrap} !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_clear got %h want 0", {rd_addr, disp_addr, disp_data, disp_valid, wrap});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({disp_valid, disp_addr, disp_data} !== {1'b1, 5'd0, 4'hA} || obs !== exp_v) begin
      miscompares++;
      $display("FAIL midrst_prime got v=%b a=%0d d=%h want v=1 a=0 d=a", disp_valid, disp_addr, disp_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d run=%b got %h want %h", c, run, obs, exp_v);
      end
    end
    run = 1'b0; step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_step();
    test_auto_scan();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
